// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters. Lookup is combinational from IF.
// Update, mispredict and redirect come from the resolved outcome in ID.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    input  logic              clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(1) << (CNT_W - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit, up_hit, br_upd;

    logic               ent_we;
    logic               ent_valid_d;
    logic [TAG_W-1:0]   ent_tag_d;
    logic [31:0]        ent_target_d;
    logic [CNT_W-1:0]   ent_cnt_d;

    assign lk_idx = if_pc[INDEX_W+1:2];
    assign lk_tag = if_pc[INDEX_W+1+TAG_W:INDEX_W+2];
    assign up_idx = upd_pc[INDEX_W+1:2];
    assign up_tag = upd_pc[INDEX_W+1+TAG_W:INDEX_W+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign br_upd = upd_valid && upd_is_branch;

    assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;

    // A non-branch that was predicted taken comes from a stale entry and must fall through.
    assign mispredict = (br_upd && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target))))
                     || (upd_valid && !upd_is_branch && upd_pred_taken);
    assign redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[up_idx];
        ent_tag_d    = tag_q[up_idx];
        ent_target_d = target_q[up_idx];
        ent_cnt_d    = cnt_q[up_idx];
        if (br_upd) begin
            if (up_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    ent_target_d = upd_target;
                    if (cnt_q[up_idx] != '1)
                        ent_cnt_d = cnt_q[up_idx] + CNT_W'(1);
                end else if (cnt_q[up_idx] != '0) begin
                    ent_cnt_d = cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = up_tag;
                ent_target_d = upd_target;
                ent_cnt_d    = CNT_WEAK_TAKEN;
            end
        end else if (upd_valid && up_hit) begin
            ent_we      = 1'b1;
            ent_valid_d = 1'b0;
        end
    end

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (br_upd && (stat_br_q != '1))
            stat_br_d = stat_br_q + STAT_W'(1);
        if (mispredict && (stat_mp_q != '1))
            stat_mp_d = stat_mp_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
            if (clear) begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                    valid_q[i] <= 1'b0;
            end else if (ent_we) begin
                valid_q[up_idx]  <= ent_valid_d;
                tag_q[up_idx]    <= ent_tag_d;
                target_q[up_idx] <= ent_target_d;
                cnt_q[up_idx]    <= ent_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor at default parameters; expected values are hand-derived.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        clear;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .STAT_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .clear(clear),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    // Presents one resolved instruction just after the falling edge, then settles.
    task automatic set_upd(input logic [31:0] pc, input logic isbr, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        @(negedge clk);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_is_branch   = isbr;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; upd_valid = 1'b0; if_pc = '0;
        upd_pc = '0; upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        @(posedge clk); #1;
        step();
        if_pc = 32'h0040_0010; #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL cold_taken: got %0b want 0", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0040_0014) $display("FAIL cold_target: got %h want 00400014", pred_target); else passed++;
        checks++; if (stat_branches !== 32'd0) $display("FAIL reset_stat_br: got %0d want 0", stat_branches); else passed++;
        checks++; if (stat_mispredicts !== 32'd0) $display("FAIL reset_stat_mp: got %0d want 0", stat_mispredicts); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict: got %0b want 0", mispredict); else passed++;
    endtask

    task automatic test_allocation();
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        checks++; if (mispredict !== 1'b1) $display("FAIL alloc_mp: got %0b want 1", mispredict); else passed++;
        checks++; if (redirect_pc !== 32'h0040_0040) $display("FAIL alloc_redirect: got %h want 00400040", redirect_pc); else passed++;
        checks++; if (pred_taken !== 1'b0) $display("FAIL same_cycle_lookup: got %0b want 0", pred_taken); else passed++;
        step();
        checks++; if (stat_mispredicts !== 32'd1) $display("FAIL alloc_stat_mp: got %0d want 1", stat_mispredicts); else passed++;
        checks++; if (stat_branches !== 32'd1) $display("FAIL alloc_stat_br: got %0d want 1", stat_branches); else passed++;
        checks++; if (pred_taken !== 1'b1) $display("FAIL alloc_lookup_taken: got %0b want 1", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0040_0040) $display("FAIL alloc_lookup_target: got %h want 00400040", pred_target); else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
            checks++; if (mispredict !== 1'b0) $display("FAIL sat_taken_mp[%0d]: got %0b want 0", i, mispredict); else passed++;
            step();
        end
        checks++; if (pred_taken !== 1'b1) $display("FAIL sat_cnt3: got %0b want 1", pred_taken); else passed++;
        set_upd(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        checks++; if (mispredict !== 1'b1) $display("FAIL nt1_mp: got %0b want 1", mispredict); else passed++;
        checks++; if (redirect_pc !== 32'h0040_0014) $display("FAIL nt1_redirect: got %h want 00400014", redirect_pc); else passed++;
        step();
        checks++; if (pred_taken !== 1'b1) $display("FAIL cnt2_taken: got %0b want 1", pred_taken); else passed++;
        set_upd(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        step();
        checks++; if (pred_taken !== 1'b0) $display("FAIL cnt1_taken: got %0b want 0", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0040_0014) $display("FAIL cnt1_target: got %h want 00400014", pred_target); else passed++;
        for (int i = 0; i < 2; i++) begin
            set_upd(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040, 1'b0, 32'h0040_0014);
            checks++; if (mispredict !== 1'b0) $display("FAIL nt_correct_mp[%0d]: got %0b want 0", i, mispredict); else passed++;
            step();
        end
        checks++; if (stat_branches !== 32'd8) $display("FAIL sat_stat_br: got %0d want 8", stat_branches); else passed++;
        checks++; if (stat_mispredicts !== 32'd3) $display("FAIL sat_stat_mp: got %0d want 3", stat_mispredicts); else passed++;
        // Counter held at 0, so one taken update lands at 1 (not taken), the next at 2.
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        step();
        checks++; if (pred_taken !== 1'b0) $display("FAIL cnt0_hold: got %0b want 0", pred_taken); else passed++;
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        step();
        checks++; if (pred_taken !== 1'b1) $display("FAIL cnt_back_to_2: got %0b want 1", pred_taken); else passed++;
        checks++; if (stat_mispredicts !== 32'd5) $display("FAIL sat_stat_mp2: got %0d want 5", stat_mispredicts); else passed++;
    endtask

    task automatic test_aliasing();
        if_pc = 32'h0040_0050; #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL alias_miss: got %0b want 0", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0040_0054) $display("FAIL alias_miss_target: got %h want 00400054", pred_target); else passed++;
        set_upd(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0080, 1'b0, 32'h0040_0054);
        checks++; if (mispredict !== 1'b1) $display("FAIL alias_mp: got %0b want 1", mispredict); else passed++;
        step();
        checks++; if (pred_target !== 32'h0040_0080) $display("FAIL alias_new_target: got %h want 00400080", pred_target); else passed++;
        if_pc = 32'h0040_0010; #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL alias_evicted: got %0b want 0", pred_taken); else passed++;
        checks++; if (stat_branches !== 32'd11) $display("FAIL alias_stat_br: got %0d want 11", stat_branches); else passed++;
    endtask

    task automatic test_wrong_target();
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        step();
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0044, 1'b1, 32'h0040_0040);
        checks++; if (mispredict !== 1'b1) $display("FAIL wt_mp: got %0b want 1", mispredict); else passed++;
        checks++; if (redirect_pc !== 32'h0040_0044) $display("FAIL wt_redirect: got %h want 00400044", redirect_pc); else passed++;
        step();
        checks++; if (pred_taken !== 1'b1) $display("FAIL wt_taken: got %0b want 1", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0040_0044) $display("FAIL wt_target: got %h want 00400044", pred_target); else passed++;
        checks++; if (stat_mispredicts !== 32'd8) $display("FAIL wt_stat_mp: got %0d want 8", stat_mispredicts); else passed++;
    endtask

    task automatic test_non_branch();
        set_upd(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0034);
        step();
        if_pc = 32'h0040_0030; #1;
        checks++; if (pred_target !== 32'h0040_0100) $display("FAIL nb_alloc_target: got %h want 00400100", pred_target); else passed++;
        set_upd(32'h0040_0030, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0040_0100);
        checks++; if (mispredict !== 1'b1) $display("FAIL nb_stale_mp: got %0b want 1", mispredict); else passed++;
        checks++; if (redirect_pc !== 32'h0040_0034) $display("FAIL nb_redirect: got %h want 00400034", redirect_pc); else passed++;
        step();
        checks++; if (pred_taken !== 1'b0) $display("FAIL nb_invalidated: got %0b want 0", pred_taken); else passed++;
        set_upd(32'h0040_0038, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_003C);
        checks++; if (mispredict !== 1'b0) $display("FAIL nb_plain_mp: got %0b want 0", mispredict); else passed++;
        step();
        checks++; if (stat_branches !== 32'd14) $display("FAIL nb_stat_br: got %0d want 14", stat_branches); else passed++;
        checks++; if (stat_mispredicts !== 32'd10) $display("FAIL nb_stat_mp: got %0d want 10", stat_mispredicts); else passed++;
    endtask

    task automatic test_clear_priority();
        set_upd(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0024);
        clear = 1'b1;
        step();
        if_pc = 32'h0040_0020; #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL clear_discards_update: got %0b want 0", pred_taken); else passed++;
        if_pc = 32'h0040_0010; #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL clear_invalidates: got %0b want 0", pred_taken); else passed++;
    endtask

    task automatic test_reset_mid();
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        step();
        set_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        reset = 1'b1;
        step();
        checks++; if (stat_branches !== 32'd0) $display("FAIL midreset_stat_br: got %0d want 0", stat_branches); else passed++;
        checks++; if (stat_mispredicts !== 32'd0) $display("FAIL midreset_stat_mp: got %0d want 0", stat_mispredicts); else passed++;
        checks++; if (pred_taken !== 1'b0) $display("FAIL midreset_lookup: got %0b want 0", pred_taken); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL midreset_mp: got %0b want 0", mispredict); else passed++;
    endtask

    initial begin
        test_reset();
        test_allocation();
        test_saturation();
        test_aliasing();
        test_wrong_target();
        test_non_branch();
        test_clear_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
